// File: rtl/mioc_zbus_master_pkg.sv
// Shared definitions for the MIOC Z80-side bus master: command encodings as
// seen on CMD_TYPE, FSM state encodings, and small command-class helpers.
package mioc_zbus_master_pkg;

   typedef enum logic [2:0] {
      CMD_MEM_RD = 3'd0,
      CMD_MEM_WR = 3'd1,
      CMD_FETCH  = 3'd2,
      CMD_IO_RD  = 3'd3,
      CMD_IO_WR  = 3'd4
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_T1    = 3'd1,
      ST_T2    = 3'd2,
      ST_TW    = 3'd3,
      ST_T3    = 3'd4,
      ST_T4    = 3'd5,
      ST_BUSAK = 3'd6
   } state_t;

   // Unused encodings 5..7 collapse onto a plain memory read.
   function automatic cmd_t decode_cmd(input logic [2:0] raw);
      cmd_t c;
      case (raw)
         3'd1:    c = CMD_MEM_WR;
         3'd2:    c = CMD_FETCH;
         3'd3:    c = CMD_IO_RD;
         3'd4:    c = CMD_IO_WR;
         default: c = CMD_MEM_RD;
      endcase
      return c;
   endfunction

   function automatic logic cmd_is_read(input cmd_t c);
      return (c == CMD_MEM_RD) || (c == CMD_FETCH) || (c == CMD_IO_RD);
   endfunction

   function automatic logic cmd_is_io(input cmd_t c);
      return (c == CMD_IO_RD) || (c == CMD_IO_WR);
   endfunction

endpackage

// File: rtl/mioc_zbus_master_rfsh_cnt.sv
// Refresh address counter (the Z80 R register), wrapping modulo 2^BITS.
//   clk_sys : clock
//   clr     : synchronous clear, wins over inc
//   inc     : advance by one
//   cnt     : current refresh address
module mioc_rfsh_cnt #(
   parameter int BITS = 7
) (
   input  logic            clk_sys,
   input  logic            clr,
   input  logic            inc,
   output logic [BITS-1:0] cnt
);

   always_ff @(posedge clk_sys) begin
      if (clr)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + BITS'(1);
   end

endmodule

// File: rtl/mioc_zbus_master.sv
// Z80-side bus-cycle initiator for the MIOC bus. A one-deep command port
// launches T-state accurate memory, opcode-fetch/refresh and I/O cycles;
// WAIT_N stretches cycles and BUSRQ_N/BUSAK_N hand the bus away while idle.
//   B_PHI, RESET                        : clock, synchronous active-high reset
//   CMD_VALID/READY/TYPE/ADDR/WDATA     : command request port
//   RSP_VALID, RSP_RDATA                : completion pulse and read data
//   BA, ADDR_OE, BD_OUT, BD_OE, BD_IN   : address and data bus
//   BMREQ_N IORQ_N BRD_N N_BWR BM1_N BRFSH_N : bus strobes
//   WAIT_N, BUSRQ_N, BUSAK_N            : wait and bus arbitration
//
// state | meaning
// IDLE  | bus parked, command or bus request may be taken
// T1    | address phase
// T2    | strobe phase, WAIT_N sampled at its end (after forced I/O waits)
// TW    | wait state (forced I/O waits, then while WAIT_N low)
// T3    | read data captured at its end; refresh starts here for fetches
// T4    | fetch only: refresh tail, R advances at its end
// BUSAK | bus released to an external master
module mioc_zbus_master
   import mioc_zbus_master_pkg::*;
#(
   parameter int RFSH_BITS = 7,
   parameter int IO_WAITS  = 1
) (
   input  logic        B_PHI,
   input  logic        RESET,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [2:0]  CMD_TYPE,
   input  logic [15:0] CMD_ADDR,
   input  logic [7:0]  CMD_WDATA,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_RDATA,
   output logic [15:0] BA,
   output logic        ADDR_OE,
   output logic [7:0]  BD_OUT,
   output logic        BD_OE,
   input  logic [7:0]  BD_IN,
   output logic        BMREQ_N,
   output logic        IORQ_N,
   output logic        BRD_N,
   output logic        N_BWR,
   output logic        BM1_N,
   output logic        BRFSH_N,
   input  logic        WAIT_N,
   input  logic        BUSRQ_N,
   output logic        BUSAK_N
);

   localparam int WCNT_W = (IO_WAITS < 2) ? 1 : $clog2(IO_WAITS + 1);

   state_t                 state, state_nxt;
   cmd_t                   cmd_q, cmd_in;
   logic [15:0]            addr_q;
   logic [7:0]             wdata_q;
   logic [7:0]             rdata_q;
   logic [WCNT_W-1:0]      wcnt;
   logic                   rsp_q;
   logic                   accept;
   logic [RFSH_BITS-1:0]   rfsh;

   assign CMD_READY = (state == ST_IDLE) && BUSRQ_N && !RESET;
   assign accept    = CMD_VALID && CMD_READY;
   assign cmd_in    = decode_cmd(CMD_TYPE);
   assign RSP_VALID = rsp_q;
   assign RSP_RDATA = rdata_q;

   mioc_rfsh_cnt #(.BITS(RFSH_BITS)) u_rfsh (
      .clk_sys (B_PHI),
      .clr     (RESET),
      .inc     (state == ST_T4),
      .cnt     (rfsh)
   );

   always_ff @(posedge B_PHI) begin
      if (RESET)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // wcnt holds the forced I/O waits still owed; WAIT_N only counts once it
   // has reached zero.
   always_ff @(posedge B_PHI) begin
      if (RESET) begin
         cmd_q   <= CMD_MEM_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wcnt    <= '0;
         rsp_q   <= 1'b0;
      end else begin
         // Leaving T3 completes every cycle type: IDLE for mem/I/O, T4 for fetch.
         rsp_q <= (state == ST_T3);
         if (accept) begin
            cmd_q   <= cmd_in;
            addr_q  <= CMD_ADDR;
            wdata_q <= CMD_WDATA;
            wcnt    <= cmd_is_io(cmd_in) ? WCNT_W'(IO_WAITS) : '0;
         end else if ((state == ST_T2 || state == ST_TW) && wcnt != '0) begin
            wcnt <= wcnt - WCNT_W'(1);
         end
         if (state == ST_T3 && cmd_is_read(cmd_q))
            rdata_q <= BD_IN;
      end
   end

   always_comb begin
      state_nxt = state;
      BA        = addr_q;
      ADDR_OE   = 1'b1;
      BD_OUT    = wdata_q;
      BD_OE     = 1'b0;
      BMREQ_N   = 1'b1;
      IORQ_N    = 1'b1;
      BRD_N     = 1'b1;
      N_BWR     = 1'b1;
      BM1_N     = 1'b1;
      BRFSH_N   = 1'b1;
      BUSAK_N   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (!BUSRQ_N)
               state_nxt = ST_BUSAK;
            else if (CMD_VALID)
               state_nxt = ST_T1;
         end
         ST_T1: begin
            state_nxt = ST_T2;
            case (cmd_q)
               CMD_FETCH:  begin BM1_N = 1'b0; BMREQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_MEM_RD: begin BMREQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_MEM_WR: begin BMREQ_N = 1'b0; BD_OE = 1'b1; end
               CMD_IO_WR:  BD_OE = 1'b1;
               default:    ;
            endcase
         end
         ST_T2, ST_TW: begin
            if (wcnt != '0 || !WAIT_N)
               state_nxt = ST_TW;
            else
               state_nxt = ST_T3;
            case (cmd_q)
               CMD_FETCH:  begin BM1_N = 1'b0; BMREQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_MEM_RD: begin BMREQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_MEM_WR: begin BMREQ_N = 1'b0; N_BWR = 1'b0; BD_OE = 1'b1; end
               CMD_IO_RD:  begin IORQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_IO_WR:  begin IORQ_N = 1'b0; N_BWR = 1'b0; BD_OE = 1'b1; end
               default:    ;
            endcase
         end
         ST_T3: begin
            state_nxt = (cmd_q == CMD_FETCH) ? ST_T4 : ST_IDLE;
            case (cmd_q)
               CMD_FETCH:  begin BA = 16'(rfsh); BMREQ_N = 1'b0; BRFSH_N = 1'b0; end
               CMD_MEM_RD: begin BMREQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_MEM_WR: begin BMREQ_N = 1'b0; N_BWR = 1'b0; BD_OE = 1'b1; end
               CMD_IO_RD:  begin IORQ_N = 1'b0; BRD_N = 1'b0; end
               CMD_IO_WR:  begin IORQ_N = 1'b0; N_BWR = 1'b0; BD_OE = 1'b1; end
               default:    ;
            endcase
         end
         ST_T4: begin
            state_nxt = ST_IDLE;
            BA        = 16'(rfsh);
            BRFSH_N   = 1'b0;
         end
         ST_BUSAK: begin
            ADDR_OE = 1'b0;
            BUSAK_N = 1'b0;
            if (BUSRQ_N)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mioc_zbus_master.sv
// Bench for mioc_zbus_master: table of command vectors with per-cycle strobe
// masks, a response scoreboard, and hand-written arbitration/reset sequences.
module tb_mioc_zbus_master;

   logic        B_PHI = 1'b0;
   logic        RESET, CMD_VALID, CMD_READY, RSP_VALID, ADDR_OE, BD_OE;
   logic [2:0]  CMD_TYPE;
   logic [15:0] CMD_ADDR, BA;
   logic [7:0]  CMD_WDATA, RSP_RDATA, BD_OUT, BD_IN;
   logic        BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N;
   logic        WAIT_N, BUSRQ_N, BUSAK_N;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [6:0]  r_model  = '0;
   logic [7:0]  last_rd  = '0;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0]  typ;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  bdin;
      int          wlo_first;
      int          wlo_last;
      int          rsp_cyc;
      logic [15:0] m_mreq, m_iorq, m_rd, m_wr, m_m1, m_rfsh, m_oe;
   } vec_t;

   vec_t vecs[11];

   mioc_zbus_master #(.RFSH_BITS(7), .IO_WAITS(1)) dut (
      .B_PHI(B_PHI), .RESET(RESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
      .BA(BA), .ADDR_OE(ADDR_OE), .BD_OUT(BD_OUT), .BD_OE(BD_OE), .BD_IN(BD_IN),
      .BMREQ_N(BMREQ_N), .IORQ_N(IORQ_N), .BRD_N(BRD_N), .N_BWR(N_BWR),
      .BM1_N(BM1_N), .BRFSH_N(BRFSH_N),
      .WAIT_N(WAIT_N), .BUSRQ_N(BUSRQ_N), .BUSAK_N(BUSAK_N)
   );

   always #5 B_PHI = ~B_PHI;

   always @(posedge B_PHI) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response scoreboard: every completion must match the oldest expectation.
   always @(negedge B_PHI) begin : mon
      exp_t e;
      if (RESET === 1'b0 && RSP_VALID === 1'b1) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(RSP_VALID), 32'd0);
         end else begin
            e = sb.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            check("rsp_rdata", 32'(RSP_RDATA), 32'(e.data));
         end
      end
   end

   function automatic vec_t mk(input logic [2:0] typ, input logic [15:0] addr,
                               input logic [7:0] wdata, input logic [7:0] bdin,
                               input int wf, input int wl, input int rsp,
                               input logic [15:0] mreq, input logic [15:0] iorq,
                               input logic [15:0] rd, input logic [15:0] wr,
                               input logic [15:0] m1, input logic [15:0] rfsh,
                               input logic [15:0] oe);
      vec_t v;
      v.typ = typ; v.addr = addr; v.wdata = wdata; v.bdin = bdin;
      v.wlo_first = wf; v.wlo_last = wl; v.rsp_cyc = rsp;
      v.m_mreq = mreq; v.m_iorq = iorq; v.m_rd = rd; v.m_wr = wr;
      v.m_m1 = m1; v.m_rfsh = rfsh; v.m_oe = oe;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      logic [8:0] act, exp;
      logic       is_rd;
      bit         ok;
      int         a;
      is_rd = !(v.typ == 3'd1 || v.typ == 3'd4);
      @(posedge B_PHI); #1;
      CMD_VALID = 1'b1; CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
      WAIT_N = 1'b1; BD_IN = ~v.bdin;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge B_PHI);
         if (CMD_READY === 1'b1) ok = 1'b1;
         else begin @(posedge B_PHI); #1; end
      end
      if (!ok) begin
         check($sformatf("ready_timeout v%0d", idx), 32'(CMD_READY), 32'd1);
         CMD_VALID = 1'b0;
         return;
      end
      a = cyc + 1;
      if (is_rd) last_rd = v.bdin;
      sb.push_back('{cyc: a + v.rsp_cyc - 1, data: last_rd});
      @(posedge B_PHI); #1;
      CMD_VALID = 1'b0;
      CMD_TYPE  = 3'($urandom);
      CMD_ADDR  = 16'($urandom);
      CMD_WDATA = 8'($urandom);
      for (int c = 1; c <= v.rsp_cyc; c++) begin
         if (c > 1) begin @(posedge B_PHI); #1; end
         WAIT_N = !(c >= v.wlo_first && c <= v.wlo_last);
         BD_IN  = (c == v.rsp_cyc - 1) ? v.bdin : ~v.bdin;
         @(negedge B_PHI);
         act = {BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUSAK_N, ADDR_OE, BD_OE};
         exp = {~v.m_mreq[c], ~v.m_iorq[c], ~v.m_rd[c], ~v.m_wr[c], ~v.m_m1[c],
                ~v.m_rfsh[c], 1'b1, 1'b1, v.m_oe[c]};
         check($sformatf("strobes v%0d c%0d", idx, c), 32'(act), 32'(exp));
         if (c == 1 || v.m_mreq[c] || v.m_iorq[c] || v.m_rfsh[c])
            check($sformatf("ba v%0d c%0d", idx, c), 32'(BA),
                  v.m_rfsh[c] ? 32'(r_model) : 32'(v.addr));
         if (v.m_oe[c])
            check($sformatf("bd_out v%0d c%0d", idx, c), 32'(BD_OUT), 32'(v.wdata));
      end
      WAIT_N = 1'b1;
      if (v.typ == 3'd2) r_model = r_model + 7'd1;
   endtask

   initial begin
      vec_t f;
      //            typ   addr      wd     bdin  wf wl rsp mreq      iorq      rd        wr        m1        rfsh      oe
      vecs[0]  = mk(3'd0, 16'h2000, 8'h00, 8'hA5, 1, 1, 4, 16'h000E, 16'h0000, 16'h000E, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[1]  = mk(3'd1, 16'h8001, 8'h3C, 8'h00, 2, 3, 6, 16'h003E, 16'h0000, 16'h0000, 16'h003C, 16'h0000, 16'h0000, 16'h003E);
      vecs[2]  = mk(3'd2, 16'h0100, 8'h00, 8'h3E, 3, 3, 4, 16'h000E, 16'h0000, 16'h0006, 16'h0000, 16'h0006, 16'h0018, 16'h0000);
      vecs[3]  = mk(3'd3, 16'h00E0, 8'h00, 8'h5A, 0, 0, 5, 16'h0000, 16'h001C, 16'h001C, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[4]  = mk(3'd4, 16'h0042, 8'h99, 8'h00, 3, 3, 6, 16'h0000, 16'h003C, 16'h0000, 16'h003C, 16'h0000, 16'h0000, 16'h003E);
      vecs[5]  = mk(3'd0, 16'hFFFF, 8'h00, 8'h00, 2, 2, 5, 16'h001E, 16'h0000, 16'h001E, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[6]  = mk(3'd6, 16'h1234, 8'h00, 8'hC3, 0, 0, 4, 16'h000E, 16'h0000, 16'h000E, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[7]  = mk(3'd2, 16'h0200, 8'h00, 8'h77, 2, 2, 5, 16'h001E, 16'h0000, 16'h000E, 16'h0000, 16'h000E, 16'h0030, 16'h0000);
      vecs[8]  = mk(3'd1, 16'h0000, 8'hFF, 8'h00, 0, 0, 4, 16'h000E, 16'h0000, 16'h0000, 16'h000C, 16'h0000, 16'h0000, 16'h000E);
      vecs[9]  = mk(3'd3, 16'h00FE, 8'h00, 8'h81, 3, 4, 7, 16'h0000, 16'h007C, 16'h007C, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[10] = mk(3'd5, 16'hABCD, 8'h00, 8'h0F, 0, 0, 4, 16'h000E, 16'h0000, 16'h000E, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

      RESET = 1'b1; CMD_VALID = 1'b0; CMD_TYPE = '0; CMD_ADDR = '0; CMD_WDATA = '0;
      BD_IN = '0; WAIT_N = 1'b1; BUSRQ_N = 1'b1;

      // Reset values
      repeat (2) @(posedge B_PHI);
      @(negedge B_PHI);
      check("rst_ready", 32'(CMD_READY), 32'd0);
      check("rst_strobes", 32'({BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N, BUSAK_N}), 32'h7F);
      check("rst_oe", 32'({ADDR_OE, BD_OE}), 32'h2);
      check("rst_ba", 32'(BA), 32'h0);
      check("rst_bd_out", 32'(BD_OUT), 32'h0);
      check("rst_rsp", 32'({RSP_VALID, RSP_RDATA}), 32'h0);
      @(posedge B_PHI); #1;
      RESET = 1'b0;
      @(negedge B_PHI);
      check("ready_after_reset", 32'(CMD_READY), 32'd1);

      for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

      // 130 fetches from R=0: refresh address walks 0..127 then 0, 1
      @(posedge B_PHI); #1; RESET = 1'b1;
      @(posedge B_PHI); #1; RESET = 1'b0; r_model = '0; last_rd = '0;
      for (int i = 0; i < 130; i++) begin
         f = mk(3'd2, 16'($urandom), 8'h00, 8'($urandom), 0, 0, 4,
                16'h000E, 16'h0000, 16'h0006, 16'h0000, 16'h0006, 16'h0018, 16'h0000);
         run_vec(f, 100 + i);
      end

      // Bus request together with a pending command
      @(posedge B_PHI); #1;
      BUSRQ_N = 1'b0; CMD_VALID = 1'b1; CMD_TYPE = 3'd0; CMD_ADDR = 16'h4444; BD_IN = 8'h44;
      @(negedge B_PHI);
      check("busrq_ready", 32'(CMD_READY), 32'd0);
      @(posedge B_PHI); #1;
      @(negedge B_PHI);
      check("busak_oe", 32'({BUSAK_N, ADDR_OE, BD_OE}), 32'h0);
      check("busak_strobes", 32'({BMREQ_N, IORQ_N, BRD_N, N_BWR, BM1_N, BRFSH_N}), 32'h3F);
      @(posedge B_PHI); #1;
      BUSRQ_N = 1'b1;
      @(negedge B_PHI);
      check("busak_hold", 32'(BUSAK_N), 32'd0);
      @(posedge B_PHI); #1;
      @(negedge B_PHI);
      check("busak_release", 32'(BUSAK_N), 32'd1);
      check("ready_after_busak", 32'(CMD_READY), 32'd1);
      last_rd = 8'h44;
      sb.push_back('{cyc: cyc + 4, data: 8'h44});
      @(posedge B_PHI); #1;
      CMD_VALID = 1'b0;
      @(negedge B_PHI);
      check("t1_after_busak", 32'({BMREQ_N, BRD_N, BA}), 32'h4444);
      repeat (4) @(posedge B_PHI);

      // Back-to-back memory reads: second accepted in the response cycle
      #1;
      CMD_VALID = 1'b1; CMD_TYPE = 3'd0; CMD_ADDR = 16'h1111; BD_IN = 8'h11;
      @(negedge B_PHI);
      check("b2b_ready1", 32'(CMD_READY), 32'd1);
      last_rd = 8'h11;
      sb.push_back('{cyc: cyc + 4, data: 8'h11});
      @(posedge B_PHI); #1;
      CMD_ADDR = 16'h2222;
      @(posedge B_PHI); #1;
      @(negedge B_PHI);
      check("b2b_busy_ready", 32'(CMD_READY), 32'd0);
      @(posedge B_PHI); #1;
      @(posedge B_PHI); #1;
      BD_IN = 8'h22;
      @(negedge B_PHI);
      check("b2b_ready2", 32'(CMD_READY), 32'd1);
      last_rd = 8'h22;
      sb.push_back('{cyc: cyc + 4, data: 8'h22});
      @(posedge B_PHI); #1;
      CMD_VALID = 1'b0;
      @(negedge B_PHI);
      check("b2b_t1", 32'({BMREQ_N, BA}), 32'h2222);
      repeat (4) @(posedge B_PHI);

      // Reset in TW of a memory write (R is 2 here)
      #1;
      CMD_VALID = 1'b1; CMD_TYPE = 3'd1; CMD_ADDR = 16'h5555; CMD_WDATA = 8'hAA; WAIT_N = 1'b0;
      @(negedge B_PHI);
      check("rst_tw_ready", 32'(CMD_READY), 32'd1);
      @(posedge B_PHI); #1;
      CMD_VALID = 1'b0;
      @(posedge B_PHI); #1;
      @(posedge B_PHI); #1;
      RESET = 1'b1;
      @(negedge B_PHI);
      check("tw_before_reset", 32'({BMREQ_N, N_BWR}), 32'h0);
      @(posedge B_PHI);
      @(negedge B_PHI);
      check("reset_release_strobes", 32'({BMREQ_N, N_BWR, BD_OE}), 32'h6);
      check("reset_no_rsp", 32'(RSP_VALID), 32'd0);
      check("reset_ready", 32'(CMD_READY), 32'd0);
      @(posedge B_PHI); #1;
      RESET = 1'b0; WAIT_N = 1'b1; r_model = '0; last_rd = '0;
      repeat (3) begin
         @(negedge B_PHI);
         check("no_rsp_after_reset", 32'(RSP_VALID), 32'd0);
      end
      run_vec(vecs[8], 200);
      run_vec(vecs[2], 201);

      repeat (3) @(posedge B_PHI);
      @(negedge B_PHI);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
